vend_dispense_ctrl: RTL and testbench

- Downstream stage of the vending-machine coin/credit FSM.
- Consumes its per-cycle request outputs: EB (deliver bottle), EB1 (return 1 leu), EB2 (return 5 lei).
- Queues the requests and turns them into timed, mutually exclusive actuator pulses: bottle motor, 1-leu solenoid, 5-lei solenoid.
- Confirms bottle delivery via a drop sensor and latches a fault on timeout.

---
 rtl/vend_pkg.sv | 37 +++
 rtl/vend_pend_cnt.sv | 54 +++++
 rtl/vend_dispense_ctrl.sv | 146 ++++++++++++++
 tb/tb_vend_dispense_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared types and default timing for the vending-machine dispense path.
// The timing constants are also used by the upstream coin/credit FSM's bench.
package vend_pkg;

   typedef enum logic [2:0] {
      IDLE,
      PULSE,
      WAIT_DROP,
      GAP,
      FAULT
   } state_e;

   // Declaration order matches service priority: bottle first, then 5 lei, then 1 leu.
   typedef enum logic [1:0] {
      CH_BOTTLE,
      CH_C5,
      CH_C1
   } chan_e;

   localparam int DEF_PULSE_CYC   = 50;
   localparam int DEF_GAP_CYC     = 20;
   localparam int DEF_TIMEOUT_CYC = 1000;
   localparam int DEF_PEND_W      = 3;

   // Actuator pattern {bottle, c5, c1} for a channel.
   function automatic logic [2:0] chanOneHot(input chan_e ch);
      logic [2:0] oh;
      case (ch)
         CH_BOTTLE: oh = 3'b100;
         CH_C5:     oh = 3'b010;
         CH_C1:     oh = 3'b001;
         default:   oh = 3'b000;
      endcase
      return oh;
   endfunction

endpackage

// File: rtl/vend_pend_cnt.sv
// Pending-request counter for one dispense channel.
// It counts up on a request and down when that channel is served.
// A request arriving while the counter is full is dropped, and the sticky overflow flag records it.
module vend_pend_cnt
   import vend_pkg::*;
#(
   parameter int W = DEF_PEND_W
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         inc_i,
   input  logic         dec_i,
   output logic [W-1:0] count_o,
   output logic         ovf_o
);

   localparam logic [W-1:0] CNT_MAX = '1;

   logic [W-1:0] count_q, count_d;
   logic         ovf_q;
   logic         dropReq;

   // Next count: a simultaneous request and service cancel; a request into a full counter is lost.
   always_comb begin
      count_d = count_q;
      dropReq = 1'b0;
      if (inc_i && !dec_i) begin
         if (count_q == CNT_MAX) begin
            dropReq = 1'b1;
         end else begin
            count_d = count_q + 1'b1;
         end
      end else if (dec_i && !inc_i) begin
         count_d = count_q - 1'b1;
      end
   end

   // Count register; the overflow flag stays set until reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         if (dropReq) begin
            ovf_q <= 1'b1;
         end
      end
   end

   assign count_o = count_q;
   assign ovf_o   = ovf_q;

endmodule

// File: rtl/vend_dispense_ctrl.sv
// Dispense controller. It queues bottle and coin-return requests from the credit FSM.
// Requests are served one at a time as timed, mutually exclusive actuator pulses.
// A cool-down follows every pulse, and bottle delivery is confirmed by the drop sensor.
module vend_dispense_ctrl
   import vend_pkg::*;
#(
   parameter int PULSE_CYC   = DEF_PULSE_CYC,
   parameter int GAP_CYC     = DEF_GAP_CYC,
   parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
   parameter int PEND_W      = DEF_PEND_W
) (
   input  logic clk,
   input  logic reset,
   input  logic EB,
   input  logic EB1,
   input  logic EB2,
   input  logic bottle_drop,
   input  logic clr_fault,
   output logic act_bottle,
   output logic act_c1,
   output logic act_c5,
   output logic busy,
   output logic fault,
   output logic ovf
);

   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TW-1:0] PULSE_LAST   = TW'(PULSE_CYC - 1);
   localparam logic [TW-1:0] GAP_LAST     = TW'(GAP_CYC - 1);
   localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYC - 1);

   state_e          state_q;
   chan_e           ch_q;
   chan_e           nextCh;
   logic [TW-1:0]   timer_q;
   logic            dropSeen_q;

   logic [PEND_W-1:0] pendB, pend5, pend1;
   logic            ovfB, ovf5, ovf1;
   logic            anyPend, gapDone, launch;
   logic            decB, dec5, dec1;
   logic [2:0]      launchAct;

   vend_pend_cnt #(.W(PEND_W)) uPendB (
      .clk_i(clk), .rst_ni(reset), .inc_i(EB),  .dec_i(decB), .count_o(pendB), .ovf_o(ovfB)
   );
   vend_pend_cnt #(.W(PEND_W)) uPend5 (
      .clk_i(clk), .rst_ni(reset), .inc_i(EB2), .dec_i(dec5), .count_o(pend5), .ovf_o(ovf5)
   );
   vend_pend_cnt #(.W(PEND_W)) uPend1 (
      .clk_i(clk), .rst_ni(reset), .inc_i(EB1), .dec_i(dec1), .count_o(pend1), .ovf_o(ovf1)
   );

   // Choose the highest-priority waiting channel and decide whether a new pulse starts on this edge.
   // A pulse may start from IDLE, or directly at the last gap cycle so that pulses keep exact spacing.
   always_comb begin
      anyPend = (pendB != '0) || (pend5 != '0) || (pend1 != '0);
      if (pendB != '0) begin
         nextCh = CH_BOTTLE;
      end else if (pend5 != '0) begin
         nextCh = CH_C5;
      end else begin
         nextCh = CH_C1;
      end
      gapDone   = (state_q == GAP) && (timer_q == GAP_LAST);
      launch    = anyPend && ((state_q == IDLE) || gapDone);
      decB      = launch && (nextCh == CH_BOTTLE);
      dec5      = launch && (nextCh == CH_C5);
      dec1      = launch && (nextCh == CH_C1);
      launchAct = chanOneHot(nextCh);
   end

   // Service FSM with registered actuator drives and a latched fault flag.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         ch_q       <= CH_BOTTLE;
         timer_q    <= '0;
         dropSeen_q <= 1'b0;
         act_bottle <= 1'b0;
         act_c5     <= 1'b0;
         act_c1     <= 1'b0;
         fault      <= 1'b0;
      end else if (launch) begin
         state_q    <= PULSE;
         ch_q       <= nextCh;
         timer_q    <= '0;
         dropSeen_q <= 1'b0;
         {act_bottle, act_c5, act_c1} <= launchAct;
      end else begin
         case (state_q)
            PULSE: begin
               if (timer_q == PULSE_LAST) begin
                  {act_bottle, act_c5, act_c1} <= 3'b000;
                  timer_q <= '0;
                  if ((ch_q == CH_BOTTLE) && !dropSeen_q && !bottle_drop) begin
                     state_q <= WAIT_DROP;
                  end else begin
                     state_q <= GAP;
                  end
               end else begin
                  timer_q <= timer_q + 1'b1;
                  if ((ch_q == CH_BOTTLE) && bottle_drop) begin
                     dropSeen_q <= 1'b1;
                  end
               end
            end
            WAIT_DROP: begin
               if (bottle_drop) begin
                  state_q <= GAP;
                  timer_q <= '0;
               end else if (timer_q == TIMEOUT_LAST) begin
                  state_q <= FAULT;
                  fault   <= 1'b1;
                  timer_q <= '0;
               end else begin
                  timer_q <= timer_q + 1'b1;
               end
            end
            GAP: begin
               if (gapDone) begin
                  state_q <= IDLE;
               end else begin
                  timer_q <= timer_q + 1'b1;
               end
            end
            FAULT: begin
               if (clr_fault) begin
                  fault   <= 1'b0;
                  state_q <= GAP;
                  timer_q <= '0;
               end
            end
            IDLE: begin
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy = (state_q != IDLE) || anyPend;
   assign ovf  = ovfB | ovf5 | ovf1;

endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// Self-checking bench for vend_dispense_ctrl.
// A reference model records queued requests as plain counts and the earliest cycle the next actuation may start.
// It pushes each pulse it expects into a queue. A monitor pops that queue whenever an actuator rises.
`timescale 1ns/1ps
module tb_vend_dispense_ctrl;
   import vend_pkg::*;

   localparam int P    = DEF_PULSE_CYC;
   localparam int G    = DEF_GAP_CYC;
   localparam int T    = DEF_TIMEOUT_CYC;
   localparam int PW   = DEF_PEND_W;
   localparam int MAXP = (1 << PW) - 1;
   localparam int BIG  = 1 << 30;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic EB = 1'b0, EB1 = 1'b0, EB2 = 1'b0, bottle_drop = 1'b0, clr_fault = 1'b0;
   logic act_bottle, act_c1, act_c5, busy, fault, ovf;

   vend_dispense_ctrl #(
      .PULSE_CYC(P), .GAP_CYC(G), .TIMEOUT_CYC(T), .PEND_W(PW)
   ) dut (
      .clk(clk), .reset(reset), .EB(EB), .EB1(EB1), .EB2(EB2),
      .bottle_drop(bottle_drop), .clr_fault(clr_fault),
      .act_bottle(act_bottle), .act_c1(act_c1), .act_c5(act_c5),
      .busy(busy), .fault(fault), .ovf(ovf)
   );

   always #5 clk = ~clk;

   typedef struct {
      int ch;
      int start;
   } pulse_t;

   pulse_t expQ[$];
   int     assertCount = 0;
   int     failCount   = 0;
   int     edgeN       = 0;

   // Model state. Channel index 0 is the bottle, 1 is 5 lei, 2 is 1 leu.
   int     mPend[3];
   bit     mFault = 1'b0;
   bit     mOvf   = 1'b0;
   int     freeAt = 0;
   bit     bLive  = 1'b0;
   int     bStart = 0, bDelay = 0, bEnd = 0;
   int     mN, mCh;
   pulse_t mE;
   bit [2:0] mReq;

   // Drop plan applied to the next bottle: edge offset from the pulse start. A value of 0 means no drop ever.
   int     dropDelay  = P + 10;
   bit     spuriousEn = 1'b0;
   int     dN;
   bit     dDrop;

   // Monitor state.
   bit       inPulse = 1'b0;
   int       pStart  = 0;
   logic [2:0] pVec  = 3'b000;
   logic [2:0] actv;
   pulse_t   popE;

   task automatic checkOutput(input string name, input longint actual, input longint expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
      end
   endtask

   function automatic int chOf(input logic [2:0] v);
      case (v)
         3'b100:  return 0;
         3'b010:  return 1;
         3'b001:  return 2;
         default: return 9;
      endcase
   endfunction

   function automatic bit modelBusy();
      return ((mPend[0] + mPend[1] + mPend[2]) > 0) || mFault || (edgeN < freeAt);
   endfunction

   // Reference model: one step per rising edge.
   // A pulse may start once the current cycle reaches freeAt.
   // freeAt is the end of the previous actuation plus the cool-down, counted from the drop or clear where that applies.
   always @(posedge clk) begin
      edgeN++;
      if (!reset) begin
         for (int c = 0; c < 3; c++) mPend[c] = 0;
         mFault = 1'b0;
         mOvf   = 1'b0;
         freeAt = 0;
         bLive  = 1'b0;
         expQ.delete();
      end else begin
         mN = edgeN;
         if (mFault && clr_fault) begin
            mFault = 1'b0;
            freeAt = mN + G;
         end
         if (bLive && (bDelay == 0) && (mN == bStart + P + T)) begin
            mFault = 1'b1;
         end
         if (!mFault && (mN >= freeAt) && ((mPend[0] + mPend[1] + mPend[2]) > 0)) begin
            mCh = (mPend[0] > 0) ? 0 : ((mPend[1] > 0) ? 1 : 2);
            mPend[mCh]--;
            mE.ch    = mCh;
            mE.start = mN;
            expQ.push_back(mE);
            if (mCh == 0) begin
               bLive  = 1'b1;
               bStart = mN;
               bDelay = dropDelay;
               if (bDelay == 0) begin
                  bEnd   = mN + P + T;
                  freeAt = BIG;
               end else begin
                  bEnd   = mN + ((bDelay > P) ? bDelay : P);
                  freeAt = bEnd + G;
               end
            end else begin
               freeAt = mN + P + G;
            end
         end
         mReq = {EB1, EB2, EB};
         for (int c = 0; c < 3; c++) begin
            if (mReq[c]) begin
               if (mPend[c] == MAXP) mOvf = 1'b1;
               else mPend[c]++;
            end
         end
      end
   end

   // Drop sensor: the planned drop for the bottle in service.
   // When enabled, it also adds stray pulses outside that bottle's window, which the controller must ignore.
   always @(negedge clk) begin
      dN    = edgeN + 1;
      dDrop = 1'b0;
      if (bLive && (bDelay != 0) && (dN == bStart + bDelay)) begin
         dDrop = 1'b1;
      end else if (spuriousEn && !(bLive && (dN > bStart) && (dN <= bEnd))
                   && ($urandom_range(0, 15) == 0)) begin
         dDrop = 1'b1;
      end
      bottle_drop = dDrop;
   end

   // Monitor: per-cycle status checks, and actuator pulses matched against the expected queue.
   always @(negedge clk) begin
      if (!reset) begin
         inPulse = 1'b0;
      end else begin
         actv = {act_bottle, act_c5, act_c1};
         checkOutput("act_onehot", ($countones(actv) > 1), 0);
         checkOutput("fault", fault, mFault);
         checkOutput("ovf", ovf, mOvf);
         checkOutput("busy", busy, modelBusy());
         if (inPulse && (actv != pVec)) begin
            checkOutput("pulse_len", edgeN - pStart, P);
            inPulse = 1'b0;
         end
         if (!inPulse && (actv != 3'b000)) begin
            inPulse = 1'b1;
            pStart  = edgeN;
            pVec    = actv;
            if (expQ.size() == 0) begin
               checkOutput("unexpected_pulse", chOf(actv), -1);
            end else begin
               popE = expQ.pop_front();
               checkOutput("pulse_chan", chOf(actv), popE.ch);
               checkOutput("pulse_start", edgeN, popE.start);
            end
         end
      end
   end

   task automatic applyStimulus(input bit b, input bit c5, input bit c1, input bit clr);
      @(negedge clk);
      EB        = b;
      EB2       = c5;
      EB1       = c1;
      clr_fault = clr;
   endtask

   task automatic waitIdle(input string name, input int maxCyc);
      int k;
      k = 0;
      do begin
         @(negedge clk);
         #1;
         k++;
      end while ((busy || modelBusy() || inPulse) && (k < maxCyc));
      checkOutput({name, "_drain_timeout"}, (k >= maxCyc), 0);
   endtask

   initial begin
      #900000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int k, mode;
      // Reset state.
      #2 reset = 1'b0;
      #1;
      checkOutput("reset_act", {act_bottle, act_c5, act_c1}, 0);
      checkOutput("reset_fault", fault, 0);
      checkOutput("reset_ovf", ovf, 0);
      checkOutput("reset_busy", busy, 0);
      repeat (3) @(negedge clk);
      #1 reset = 1'b1;

      $display("[TB] single bottle, drop 10 cycles after pulse");
      dropDelay = P + 10;
      applyStimulus(1, 0, 0, 0);
      applyStimulus(0, 0, 0, 0);
      waitIdle("t1", 2000);

      $display("[TB] three 1-leu requests back to back");
      applyStimulus(0, 0, 1, 0);
      applyStimulus(0, 0, 1, 0);
      applyStimulus(0, 0, 1, 0);
      applyStimulus(0, 0, 0, 0);
      waitIdle("t2", 2000);

      $display("[TB] bottle and 5 lei together, drop during pulse");
      dropDelay = 20;
      applyStimulus(1, 1, 0, 0);
      applyStimulus(0, 0, 0, 0);
      waitIdle("t3", 2000);

      $display("[TB] bottle without drop, then fault clear");
      dropDelay = 0;
      applyStimulus(1, 0, 0, 0);
      applyStimulus(0, 0, 0, 0);
      repeat (5) @(negedge clk);
      applyStimulus(0, 0, 1, 0);
      applyStimulus(0, 0, 0, 0);
      repeat (P + T + 30) @(negedge clk);
      #1;
      checkOutput("t4_fault_latched", fault, 1);
      checkOutput("t4_no_act_in_fault", {act_bottle, act_c5, act_c1}, 0);
      applyStimulus(0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0);
      waitIdle("t4", 2000);
      dropDelay = P + 10;

      $display("[TB] nine 1-leu requests, counter overflow");
      for (int i = 0; i < 9; i++) applyStimulus(0, 0, 1, 0);
      applyStimulus(0, 0, 0, 0);
      waitIdle("t5", 3000);
      checkOutput("t5_ovf_set", ovf, 1);

      $display("[TB] async reset in the middle of a 5-lei pulse");
      applyStimulus(0, 1, 0, 0);
      applyStimulus(0, 0, 0, 0);
      k = 0;
      while (!act_c5 && (k < 20)) begin
         @(negedge clk);
         k++;
      end
      checkOutput("t6_c5_started", act_c5, 1);
      repeat (25) @(posedge clk);
      #2 reset = 1'b0;
      #1;
      checkOutput("t6_async_act_c5", act_c5, 0);
      checkOutput("t6_async_act_all", {act_bottle, act_c5, act_c1}, 0);
      checkOutput("t6_async_busy", busy, 0);
      checkOutput("t6_async_ovf", ovf, 0);
      repeat (3) @(negedge clk);
      #1 reset = 1'b1;
      repeat (200) @(negedge clk);
      checkOutput("t6_no_pulses_after_reset", expQ.size(), 0);
      checkOutput("t6_ovf_after_reset", ovf, 0);

      $display("[TB] randomized traffic");
      spuriousEn = 1'b1;
      for (int ph = 0; ph < 4; ph++) begin
         mode = $urandom_range(0, 2);
         if (mode == 0) dropDelay = $urandom_range(1, P);
         else if (mode == 1) dropDelay = $urandom_range(P + 1, P + 60);
         else dropDelay = P + T;
         for (int i = 0; i < 150; i++) begin
            applyStimulus(($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0),
                          ($urandom_range(0, 15) == 0), ($urandom_range(0, 63) == 0));
         end
         applyStimulus(0, 0, 0, 0);
         waitIdle("rand", 20000);
      end
      spuriousEn = 1'b0;

      repeat (5) @(negedge clk);
      checkOutput("expq_empty", expQ.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
